axil_manager: RTL

AXIL_MANAGER -- requirements
Module: axil_manager

---
 rtl/axil_manager_pkg.sv | 18 +
 rtl/axil_watchdog.sv | 27 ++
 rtl/axil_manager.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/axil_manager_pkg.sv
// Shared types and constants for the AXI-lite single-transaction manager.
package axil_manager_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RESPOND
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_watchdog.sv
// Stall watchdog: counts cycles spent in one waiting state, sets a sticky flag at 2**TIMEOUT_LG.
module axil_watchdog #(
  parameter int unsigned TIMEOUT_LG = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic timeout_err
);

  logic [TIMEOUT_LG-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      timeout_err <= 1'b0;
    end else if (!active || restart) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
      // all-ones means this is the 2**TIMEOUT_LG-th waiting cycle; wrap afterwards is harmless
      if (&count) timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/axil_manager.sv
// AXI-lite manager: turns one command into one AXI-lite read or write and returns one response.
// Optional watchdog enabled by defining AXIL_MANAGER_TIMEOUT_EN.
module axil_manager
  import axil_manager_pkg::*;
#(
  parameter  int unsigned C_AXI_ADDR_WIDTH = 4,
  parameter  int unsigned TIMEOUT_LG       = 4,
  localparam int unsigned C_AXI_DATA_WIDTH = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  output logic                          timeout_err
);

  state_t state, next_state;
  logic   started;
  logic   [C_AXI_ADDR_WIDTH-1:0] addr_q;
  logic   cmd_fire, aw_fire, w_fire, ar_fire, b_fire, r_fire;

  // started holds cmd_ready low while reset is asserted and up to the first clock edge after release
  assign cmd_ready     = started && (state == IDLE);
  assign M_AXI_BREADY  = (state == WR_RESP);
  assign M_AXI_RREADY  = (state == RD_RESP);
  assign rsp_valid     = (state == RESPOND);
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire   = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_fire  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign b_fire   = M_AXI_BVALID && M_AXI_BREADY;
  assign r_fire   = M_AXI_RVALID && M_AXI_RREADY;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= next_state;
      started <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_fire) next_state = cmd_write ? WR_REQ : RD_REQ;
      // each channel is done once its valid has dropped or is handshaking now
      WR_REQ:  if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY))
                 next_state = WR_RESP;
      WR_RESP: if (b_fire) next_state = RESPOND;
      RD_REQ:  if (ar_fire) next_state = RD_RESP;
      RD_RESP: if (r_fire) next_state = RESPOND;
      RESPOND: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      addr_q        <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q        <= cmd_addr;
        M_AXI_WDATA   <= cmd_wdata;
        M_AXI_WSTRB   <= cmd_wstrb;
        rsp_write     <= cmd_write;
        M_AXI_AWVALID <= cmd_write;
        M_AXI_WVALID  <= cmd_write;
        M_AXI_ARVALID <= !cmd_write;
      end
      if (aw_fire) M_AXI_AWVALID <= 1'b0;
      if (w_fire)  M_AXI_WVALID  <= 1'b0;
      if (ar_fire) M_AXI_ARVALID <= 1'b0;
      if (b_fire) begin
        rsp_rdata <= '0;
        rsp_resp  <= M_AXI_BRESP;
      end
      if (r_fire) begin
        rsp_rdata <= M_AXI_RDATA;
        rsp_resp  <= M_AXI_RRESP;
      end
    end
  end

`ifdef AXIL_MANAGER_TIMEOUT_EN
  logic wd_active;
  assign wd_active = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);

  axil_watchdog #(
    .TIMEOUT_LG (TIMEOUT_LG)
  ) u_watchdog (
    .clk         (M_AXI_ACLK),
    .rst_n       (M_AXI_ARESETN),
    .active      (wd_active),
    .restart     (next_state != state),
    .timeout_err (timeout_err)
  );
`else
  assign timeout_err = 1'b0;
`endif

endmodule
